// File: rtl/mm_master_arbiter.sv
// Two-requester arbiter in front of an Avalon read master and write master.
// One single-word transaction is outstanding at a time; each wait state is bounded by TIMEOUT.
module mm_master_arbiter #(
    parameter int unsigned ADDRESSWIDTH = 28,
    parameter int unsigned DATAWIDTH    = 32,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_we,
    input  logic [2*ADDRESSWIDTH-1:0] req_addr,
    input  logic [2*DATAWIDTH-1:0]    req_wdata,
    output logic [1:0]                req_grant,
    output logic [1:0]                req_done,
    output logic [1:0]                req_err,
    output logic [DATAWIDTH-1:0]      rsp_rdata,
    input  logic                      write_control_done,
    output logic [ADDRESSWIDTH-1:0]   write_control_write_base,
    output logic                      write_control_go,
    output logic                      write_user_write_buffer,
    output logic [DATAWIDTH-1:0]      write_user_buffer_data,
    input  logic                      write_user_buffer_full,
    input  logic                      read_control_done,
    output logic [ADDRESSWIDTH-1:0]   read_control_read_base,
    output logic                      read_control_go,
    output logic                      read_user_read_buffer,
    input  logic [DATAWIDTH-1:0]      read_user_buffer_output_data,
    input  logic                      read_user_data_available
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_GO   = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_RD_POP  = 3'd3;
    localparam logic [2:0] S_WR_GO   = 3'd4;
    localparam logic [2:0] S_WR_WAIT = 3'd5;
    localparam logic [2:0] S_RESP    = 3'd6;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [2:0]              state_q, state_d;
    logic                    rr_q, rr_d;
    logic                    id_q, id_d;
    logic                    we_q, we_d;
    logic                    err_q, err_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic [DATAWIDTH-1:0]    wdata_q, wdata_d;
    logic [DATAWIDTH-1:0]    rdata_q, rdata_d;

    logic                    sel;
    logic                    timed;
    logic                    to_hit;
    logic [1:0]              grant_c;
    logic                    rd_go_c, rd_pop_c, wr_go_c, done_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            we_q    <= we_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign to_hit = (cnt_q == TO_LAST);
    assign sel    = (req_valid == 2'b11) ? rr_q : req_valid[1];

    // Next-state, grant and master strobes; completion is tested before timeout so it wins a tie.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        id_d     = id_q;
        we_d     = we_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        grant_c  = 2'b00;
        rd_go_c  = 1'b0;
        rd_pop_c = 1'b0;
        wr_go_c  = 1'b0;
        done_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!reset && (req_valid != 2'b00)) begin
                    grant_c = sel ? 2'b10 : 2'b01;
                    id_d    = sel;
                    we_d    = sel ? req_we[1] : req_we[0];
                    addr_d  = sel ? req_addr[2*ADDRESSWIDTH-1:ADDRESSWIDTH]
                                  : req_addr[ADDRESSWIDTH-1:0];
                    wdata_d = sel ? req_wdata[2*DATAWIDTH-1:DATAWIDTH]
                                  : req_wdata[DATAWIDTH-1:0];
                    rr_d    = ~sel;
                    err_d   = 1'b0;
                    state_d = we_d ? S_WR_GO : S_RD_GO;
                end
            end
            S_RD_GO: begin
                rd_go_c = 1'b1;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (read_control_done) begin
                    state_d = S_RD_POP;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RD_POP: begin
                if (read_user_data_available) begin
                    rd_pop_c = 1'b1;
                    rdata_d  = read_user_buffer_output_data;
                    state_d  = S_RESP;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WR_GO: begin
                if (!write_user_buffer_full) begin
                    wr_go_c = 1'b1;
                    state_d = S_WR_WAIT;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WR_WAIT: begin
                if (write_control_done) begin
                    state_d = S_RESP;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Wait-state counter restarts on every state change.
    assign timed = (state_q == S_RD_WAIT) || (state_q == S_RD_POP) ||
                   (state_q == S_WR_GO)   || (state_q == S_WR_WAIT);

    always_comb begin
        cnt_d = 8'd0;
        if (timed && (state_d == state_q)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign req_grant                = grant_c;
    assign req_done                 = done_c ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign req_err                  = (done_c && err_q) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata                = rdata_q;
    assign read_control_go          = rd_go_c;
    assign read_user_read_buffer    = rd_pop_c;
    assign read_control_read_base   = addr_q;
    assign write_control_go         = wr_go_c;
    assign write_user_write_buffer  = wr_go_c;
    assign write_control_write_base = addr_q;
    assign write_user_buffer_data   = wdata_q;

endmodule

// File: tb/tb_mm_master_arbiter.sv
// Directed bench for mm_master_arbiter with behavioural read/write master responders.
`timescale 1ns/1ps
module tb_mm_master_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req_valid;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_grant, req_done, req_err;
    logic [DW-1:0]   rsp_rdata;
    logic            write_control_done = 1'b0;
    logic [AW-1:0]   write_control_write_base;
    logic            write_control_go, write_user_write_buffer;
    logic [DW-1:0]   write_user_buffer_data;
    logic            write_user_buffer_full;
    logic            read_control_done = 1'b0;
    logic [AW-1:0]   read_control_read_base;
    logic            read_control_go, read_user_read_buffer;
    logic [DW-1:0]   read_user_buffer_output_data;
    logic            read_user_data_available;

    int n_checks = 0;
    int n_errors = 0;
    int rd_delay = 1;
    int wr_delay = 1;
    int cyc = 0;
    int n_rgo = 0, n_pop = 0, n_wgo = 0, n_push = 0, n_split = 0, n_dual = 0, n_done = 0;
    int wgo_cyc = 0;
    logic [AW-1:0] rbase_seen = '0, wbase_seen = '0;
    logic [DW-1:0] wdata_seen = '0;

    mm_master_arbiter #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_grant(req_grant), .req_done(req_done), .req_err(req_err), .rsp_rdata(rsp_rdata),
        .write_control_done(write_control_done),
        .write_control_write_base(write_control_write_base),
        .write_control_go(write_control_go),
        .write_user_write_buffer(write_user_write_buffer),
        .write_user_buffer_data(write_user_buffer_data),
        .write_user_buffer_full(write_user_buffer_full),
        .read_control_done(read_control_done),
        .read_control_read_base(read_control_read_base),
        .read_control_go(read_control_go),
        .read_user_read_buffer(read_user_read_buffer),
        .read_user_buffer_output_data(read_user_buffer_output_data),
        .read_user_data_available(read_user_data_available)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (req_grant == 2'b11) n_dual <= n_dual + 1;
            if (read_control_go) begin
                n_rgo      <= n_rgo + 1;
                rbase_seen <= read_control_read_base;
            end
            if (read_user_read_buffer) n_pop <= n_pop + 1;
            if (write_control_go) begin
                n_wgo      <= n_wgo + 1;
                wbase_seen <= write_control_write_base;
                wdata_seen <= write_user_buffer_data;
                wgo_cyc    <= cyc;
            end
            if (write_user_write_buffer) n_push <= n_push + 1;
            if (write_control_go != write_user_write_buffer) n_split <= n_split + 1;
            if (req_done != 2'b00) n_done <= n_done + 1;
        end
    end

    // Read master: done pulse rd_delay cycles after go (0 = never).
    initial forever begin
        @(negedge clk);
        if (read_control_go && !reset && rd_delay != 0) begin
            repeat (rd_delay) @(posedge clk);
            #1 read_control_done = 1'b1;
            @(posedge clk);
            #1 read_control_done = 1'b0;
        end
    end

    // Write master: done pulse wr_delay cycles after go (0 = never).
    initial forever begin
        @(negedge clk);
        if (write_control_go && !reset && wr_delay != 0) begin
            repeat (wr_delay) @(posedge clk);
            #1 write_control_done = 1'b1;
            @(posedge clk);
            #1 write_control_done = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Raise one request (called just after a posedge); returns one cycle after the grant.
    task automatic do_req(input int id, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int gcyc);
        bit got = 0;
        req_we[id] = we;
        if (id == 1) begin
            req_addr[2*AW-1:AW] = a;
            req_wdata[2*DW-1:DW] = d;
        end else begin
            req_addr[AW-1:0] = a;
            req_wdata[DW-1:0] = d;
        end
        req_valid[id] = 1'b1;
        gcyc = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_grant != 2'b00) begin
                got  = 1;
                gcyc = cyc;
                check("grant_id", 64'(req_grant), (id == 1) ? 64'h2 : 64'h1);
            end
        end
        if (!got) check("grant_budget", 64'(0), 64'(1));
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic wait_done(output int dcyc, output logic [1:0] d, output logic [1:0] e);
        bit got = 0;
        dcyc = 0; d = 2'b00; e = 2'b00;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (req_done != 2'b00) begin
                got = 1; dcyc = cyc; d = req_done; e = req_err;
            end
        end
        if (!got) check("done_budget", 64'(0), 64'(1));
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    int g, dc, base_rgo, base_pop, base_wgo, base_push, base_done;
    logic [1:0] dv, ev;
    logic [3:0] order;
    int ngr;

    initial begin
        reset = 1'b1;
        req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
        write_user_buffer_full = 1'b0;
        read_user_buffer_output_data = 32'hAAAA0000;
        read_user_data_available = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_strobes", 64'({req_grant, req_done, req_err, write_control_go,
              write_user_write_buffer, read_control_go, read_user_read_buffer}), 64'(0));
        check("rst_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_base", 64'({write_control_write_base, read_control_read_base}), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        // Single read by requester 0, done three cycles after go.
        rd_delay = 3;
        base_rgo = n_rgo; base_pop = n_pop;
        do_req(0, 1'b0, 28'h8000000, 32'h0, g);
        wait_done(dc, dv, ev);
        check("rd_latency", 64'(dc - g), 64'(6));
        check("rd_done_id", 64'(dv), 64'h1);
        check("rd_err", 64'(ev), 64'h0);
        check("rd_rdata", 64'(rsp_rdata), 64'hAAAA0000);
        check("rd_go_count", 64'(n_rgo - base_rgo), 64'(1));
        check("rd_pop_count", 64'(n_pop - base_pop), 64'(1));
        check("rd_base", 64'(rbase_seen), 64'h8000000);

        // Both requesters held after reset: strict alternation starting at 0.
        pulse_reset();
        rd_delay = 1;
        req_we = 2'b00; req_addr = {28'h0000100, 28'h0000200};
        req_valid = 2'b11;
        ngr = 0; order = 4'b0;
        for (int i = 0; i < 60 && ngr < 4; i++) begin
            @(negedge clk);
            if (req_grant != 2'b00) begin
                order[ngr] = req_grant[1];
                ngr++;
            end
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        wait_done(dc, dv, ev);
        check("rr_count", 64'(ngr), 64'(4));
        check("rr_order", 64'(order), 64'hA);
        check("rr_dual", 64'(n_dual), 64'(0));

        // Minimum read and write latency.
        do_req(0, 1'b0, 28'h0000040, 32'h0, g);
        wait_done(dc, dv, ev);
        check("rd_min_latency", 64'(dc - g), 64'(4));
        wr_delay = 1;
        do_req(0, 1'b1, 28'h0000044, 32'hCAFE0001, g);
        wait_done(dc, dv, ev);
        check("wr_min_latency", 64'(dc - g), 64'(3));

        // Write by requester 1 held off by a full buffer for five cycles.
        wr_delay = 2;
        write_user_buffer_full = 1'b1;
        base_wgo = n_wgo; base_push = n_push;
        do_req(1, 1'b1, 28'h8000004, 32'h12345678, g);
        repeat (5) @(posedge clk);
        check("wr_hold_no_go", 64'(n_wgo - base_wgo), 64'(0));
        check("wr_hold_no_push", 64'(n_push - base_push), 64'(0));
        #1 write_user_buffer_full = 1'b0;
        wait_done(dc, dv, ev);
        check("wr_go_cycle", 64'(wgo_cyc - g), 64'(6));
        check("wr_go_count", 64'(n_wgo - base_wgo), 64'(1));
        check("wr_push_count", 64'(n_push - base_push), 64'(1));
        check("wr_go_push_paired", 64'(n_split), 64'(0));
        check("wr_data", 64'(wdata_seen), 64'h12345678);
        check("wr_base", 64'(wbase_seen), 64'h8000004);
        check("wr_done_id", 64'(dv), 64'h2);
        check("wr_err", 64'(ev), 64'h0);
        check("wr_latency", 64'(dc - g), 64'(9));

        // Read timeout: 16 RD_WAIT cycles then RESP with err, rdata untouched.
        rd_delay = 0;
        read_user_buffer_output_data = 32'hDEADBEEF;
        base_pop = n_pop;
        do_req(0, 1'b0, 28'h0000080, 32'h0, g);
        wait_done(dc, dv, ev);
        check("to_latency", 64'(dc - g), 64'(18));
        check("to_done_id", 64'(dv), 64'h1);
        check("to_err", 64'(ev), 64'h1);
        check("to_rdata_kept", 64'(rsp_rdata), 64'hAAAA0000);
        check("to_no_pop", 64'(n_pop - base_pop), 64'(0));
        @(negedge clk);
        check("to_done_one_cycle", 64'(req_done), 64'h0);
        @(posedge clk);
        #1;

        // Write done on the last allowed cycle wins; one cycle later it times out.
        wr_delay = 16;
        do_req(1, 1'b1, 28'h00000C0, 32'h0BADF00D, g);
        wait_done(dc, dv, ev);
        check("tie_latency", 64'(dc - g), 64'(18));
        check("tie_done_id", 64'(dv), 64'h2);
        check("tie_err", 64'(ev), 64'h0);
        repeat (2) @(posedge clk);
        #1 wr_delay = 17;
        do_req(1, 1'b1, 28'h00000C4, 32'h0BADF00E, g);
        wait_done(dc, dv, ev);
        check("late_latency", 64'(dc - g), 64'(18));
        check("late_err", 64'(ev), 64'h2);
        repeat (3) @(posedge clk);
        #1;

        // Reset in WR_WAIT: outputs clear at once, no done, requester 0 wins next.
        wr_delay = 0;
        rd_delay = 1;
        read_user_buffer_output_data = 32'h5A5A5A5A;
        do_req(0, 1'b1, 28'h0000100, 32'h77777777, g);
        repeat (3) @(posedge clk);
        #1 req_we = 2'b00; req_valid = 2'b11;
        base_done = n_done;
        #2 reset = 1'b1;
        #1;
        check("arst_strobes", 64'({req_grant, req_done, req_err, write_control_go,
              write_user_write_buffer, read_control_go, read_user_read_buffer}), 64'(0));
        check("arst_rdata", 64'(rsp_rdata), 64'(0));
        check("arst_wbus", 64'({write_control_write_base, write_user_buffer_data}), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("arst_first_grant", 64'(req_grant), 64'h1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        wait_done(dc, dv, ev);
        check("arst_done_id", 64'(dv), 64'h1);
        check("arst_done_count", 64'(n_done - base_done), 64'(1));
        check("arst_rdata_new", 64'(rsp_rdata), 64'h5A5A5A5A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mm_master_arbiter.md
MM_MASTER_ARBITER -- requirements
Module: mm_master_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRESSWIDTH, default 28, Avalon master byte-address width.
REQ-002 The block SHALL have parameter DATAWIDTH, default 32, data word width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, range 1-255, cycles allowed in any wait state before abort.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  2  per-requester transaction request; bit 0 = block loader, bit 1 = nonce reporter.
REQ-007 req_we  in  2  per-requester direction: 1 = write, 0 = read.
REQ-008 req_addr  in  2*ADDRESSWIDTH  per-requester address; requester n uses slice n.
REQ-009 req_wdata  in  2*DATAWIDTH  per-requester write data; requester n uses slice n.
REQ-010 req_grant  out  2  one-cycle accept pulse.
REQ-011 req_done  out  2  one-cycle completion pulse.
REQ-012 req_err  out  2  timeout flag, valid only with req_done.
REQ-013 rsp_rdata  out  DATAWIDTH  last read word, shared by both requesters.
REQ-014 write_control_done  in  1  write master finished.
REQ-015 write_control_write_base  out  ADDRESSWIDTH  write address.
REQ-016 write_control_go  out  1  write start strobe.
REQ-017 write_user_write_buffer  out  1  write-FIFO push.
REQ-018 write_user_buffer_data  out  DATAWIDTH  write-FIFO data.
REQ-019 write_user_buffer_full  in  1  write FIFO full.
REQ-020 read_control_done  in  1  read master finished.
REQ-021 read_control_read_base  out  ADDRESSWIDTH  read address.
REQ-022 read_control_go  out  1  read start strobe.
REQ-023 read_user_read_buffer  out  1  read-FIFO pop.
REQ-024 read_user_buffer_output_data  in  DATAWIDTH  read-FIFO show-ahead data.
REQ-025 read_user_data_available  in  1  read-FIFO not empty.

Function
REQ-026 The block SHALL keep at most one transaction outstanding; transfer length and fixed-location controls are tied at top level (4 bytes, fixed).
REQ-027 The block SHALL use states IDLE, RD_GO, RD_WAIT, RD_POP, WR_GO, WR_WAIT and RESP.
REQ-028 In IDLE, the block SHALL grant according to these rules:
- Exactly one req_valid high: grant that requester.
- Both high: grant the requester selected by the round-robin pointer.
- req_grant is combinational in IDLE and lasts one cycle.
- At grant, latch we, addr, wdata and requester id; set the pointer to the other requester.
- Next state: RD_GO if we=0, WR_GO if we=1.
REQ-029 Requesters SHALL hold request fields until grant; a req_valid still high in a later IDLE cycle SHALL be treated as a new request.
REQ-030 RD_GO SHALL assert read_control_go for exactly one cycle with read_control_read_base equal to the latched address, then go to RD_WAIT.
REQ-031 RD_WAIT SHALL hold until read_control_done=1, then go to RD_POP.
REQ-032 In RD_POP, in the first cycle with read_user_data_available=1, the block SHALL:
- pulse read_user_read_buffer for that cycle only;
- capture read_user_buffer_output_data into rsp_rdata;
- go to RESP.
REQ-033 WR_GO SHALL hold with all strobes low while write_user_buffer_full=1.
REQ-034 In the first WR_GO cycle with write_user_buffer_full=0, the block SHALL assert write_control_go and write_user_write_buffer together for one cycle, drive the latched data and address, and go to WR_WAIT.
REQ-035 WR_WAIT SHALL hold until write_control_done=1, then go to RESP.
REQ-036 RESP SHALL pulse req_done[id] for one cycle and return to IDLE; rsp_rdata SHALL hold its value until the next read capture.
REQ-037 The timeout counter SHALL behave as follows:
- 8 bits wide.
- Cleared on entry to RD_WAIT, RD_POP, WR_GO and WR_WAIT.
- Increments each cycle spent in those states.
- Reaching TIMEOUT forces RESP with req_err[id]=1; rsp_rdata stays unchanged.
REQ-038 If a completion (done or data_available) and TIMEOUT occur in the same cycle, completion SHALL win and req_err SHALL be 0.
REQ-039 Minimum read latency SHALL be 4 cycles from grant to req_done (done and data available immediately); minimum write latency SHALL be 3 cycles.
REQ-040 All master strobes SHALL be 0 in every state other than those named above.

Reset
REQ-041 While reset=1, the block SHALL immediately (asynchronously) hold these values:
- state IDLE, round-robin pointer 0;
- timeout counter 0, latched fields 0, rsp_rdata 0;
- all outputs 0.
REQ-042 Reset during any transaction SHALL abandon it without req_done; after release, requester 0 SHALL win the first simultaneous request.

Verification
REQ-043 Read by req0, addr 0x8000000; read_control_done 3 cycles after go; data 0xAAAA0000 available -> grant0, one go with base 0x8000000, one pop, done0 with rsp_rdata=0xAAAA0000, err0=0.
REQ-044 Both valid held for four transactions after reset -> grants in order 0,1,0,1; no cycle with two grants.
REQ-045 Write by req1, addr 0x8000004, data 0x12345678; buffer_full high 5 cycles -> single-cycle go+push after full drops with data 0x12345678; done1 after write_control_done.
REQ-046 TIMEOUT=16, read_control_done never asserted -> done0 and err0 on the 16th RD_WAIT cycle, then IDLE.
REQ-047 Reset pulsed in WR_WAIT -> outputs 0 asynchronously, no done; then simultaneous requests -> req0 granted first.
REQ-048 write_control_done arrives on the TIMEOUT cycle -> done1 with err1=0.
